// File: rtl/maxnet_n_if.sv
// Start/result bundle for maxnet_n: configuration and activations in,
// status, winner and final vector out.
interface maxnet_n_if #(
   parameter int N     = 8,
   parameter int W     = 16,
   parameter int EPS_W = 9
);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   logic             start;
   logic [EPS_W-1:0] epsilon;
   logic [N*W-1:0]   a_in;
   logic             busy;
   logic             done;
   logic             winner_valid;
   logic [IDX_W-1:0] winner_idx;
   logic [W-1:0]     winner_val;
   logic [7:0]       iter_count;
   logic             timeout;
   logic [N*W-1:0]   a_out;

   modport master (
      output start, epsilon, a_in,
      input  busy, done, winner_valid, winner_idx, winner_val,
             iter_count, timeout, a_out
   );

   modport slave (
      input  start, epsilon, a_in,
      output busy, done, winner_valid, winner_idx, winner_val,
             iter_count, timeout, a_out
   );
endinterface

// File: rtl/maxnet_n.sv
// N-channel Maxnet winner-take-all using one shared multiply-subtract lane.
// MAXNET_ITER_LIMIT_EN: stop after MAX_ITER iterations and flag timeout.
//
// state  | meaning
// IDLE   | waiting for start; captures a_in and epsilon
// LOAD   | clears accumulator, channel counter and nonzero tally
// SUM    | accumulates S over all channels, one per cycle
// UPDATE | a[k] <= max(0, a[k] - eps*(S - a[k])), one channel per cycle
// CHECK  | bumps iteration count, decides finish or another pass
// DONE   | one-cycle done pulse with registered results
module maxnet_n #(
   parameter int N        = 8,
   parameter int W        = 16,
   parameter int EPS_W    = 9,
   parameter int EPS_FRAC = 8,
   parameter int MAX_ITER = 255
) (
   input logic       clk,
   input logic       rst,
   maxnet_n_if.slave bus
);
   localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
   localparam int S_W    = W + $clog2(N);
   localparam int PROD_W = EPS_W + S_W;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
`ifdef MAXNET_ITER_LIMIT_EN
   localparam logic LIMIT_EN = 1'b1;
`else
   localparam logic LIMIT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, LOAD, SUM, UPDATE, CHECK, DONE} state_t;
   state_t state, state_nxt;

   logic [W-1:0]      a_reg [N];
   logic [EPS_W-1:0]  eps_reg;
   logic [S_W-1:0]    acc;
   logic [IDX_W-1:0]  cnt;
   logic [IDX_W-1:0]  last_idx;
   logic [1:0]        nz_cnt;
   logic [7:0]        iter_cnt, iter_nxt;
   logic              cnt_tc, converged, cap_hit;
   logic [W-1:0]      a_k, a_new;
   logic [S_W-1:0]    others;
   logic [PROD_W-1:0] prod, p;

   // Channel counter runs down, so terminal count is simply zero.
   assign cnt_tc    = (cnt == '0);
   assign a_k       = a_reg[cnt];
   assign others    = acc - S_W'(a_k);
   assign prod      = PROD_W'(eps_reg) * PROD_W'(others);
   assign p         = prod >> EPS_FRAC;
   assign a_new     = (p >= PROD_W'(a_k)) ? '0 : a_k - p[W-1:0];
   assign iter_nxt  = (iter_cnt == 8'hFF) ? 8'hFF : iter_cnt + 8'd1;
   assign converged = (nz_cnt <= 2'd1);
   assign cap_hit   = LIMIT_EN && (iter_nxt == 8'(MAX_ITER));

   for (genvar g = 0; g < N; g++) begin : g_aout
      assign bus.a_out[g*W +: W] = a_reg[g];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = LOAD;
         LOAD:    state_nxt = SUM;
         SUM:     if (cnt_tc) state_nxt = UPDATE;
         UPDATE:  if (cnt_tc) state_nxt = CHECK;
         CHECK:   state_nxt = (converged || cap_hit) ? DONE : SUM;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) a_reg[i] <= '0;
         eps_reg          <= '0;
         acc              <= '0;
         cnt              <= '0;
         last_idx         <= '0;
         nz_cnt           <= '0;
         iter_cnt         <= '0;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
         bus.winner_valid <= 1'b0;
         bus.winner_idx   <= '0;
         bus.winner_val   <= '0;
         bus.iter_count   <= '0;
         bus.timeout      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  for (int i = 0; i < N; i++) a_reg[i] <= bus.a_in[i*W +: W];
                  eps_reg  <= bus.epsilon;
                  iter_cnt <= '0;
                  bus.busy <= 1'b1;
               end
            end
            LOAD: begin
               acc      <= '0;
               cnt      <= LAST;
               nz_cnt   <= '0;
               last_idx <= '0;
            end
            SUM: begin
               acc <= acc + S_W'(a_k);
               cnt <= cnt_tc ? LAST : cnt - 1'b1;
            end
            UPDATE: begin
               a_reg[cnt] <= a_new;
               if (a_new != '0) begin
                  nz_cnt   <= (nz_cnt == 2'd2) ? 2'd2 : nz_cnt + 2'd1;
                  last_idx <= cnt;
               end
               if (!cnt_tc) cnt <= cnt - 1'b1;
            end
            CHECK: begin
               iter_cnt <= iter_nxt;
               if (converged || cap_hit) begin
                  bus.done         <= 1'b1;
                  bus.busy         <= 1'b0;
                  bus.winner_valid <= (nz_cnt == 2'd1);
                  bus.winner_idx   <= (nz_cnt == 2'd1) ? last_idx : '0;
                  bus.winner_val   <= (nz_cnt == 2'd1) ? a_reg[last_idx] : '0;
                  bus.iter_count   <= iter_nxt;
                  bus.timeout      <= !converged;
               end else begin
                  // Re-arm here instead of revisiting LOAD so a pass costs 2N+1 cycles.
                  acc      <= '0;
                  cnt      <= LAST;
                  nz_cnt   <= '0;
                  last_idx <= '0;
               end
            end
            DONE: bus.done <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_maxnet_n.sv
// Scoreboard bench for maxnet_n: directed cases plus random vectors checked
// against a whole-vector (simultaneous update) reference model.
module tb_maxnet_n;
   localparam int N        = 4;
   localparam int W        = 16;
   localparam int EPS_W    = 9;
   localparam int EPS_FRAC = 8;
   localparam int MAX_ITER = 16;

   typedef struct {
      string          name;
      int             st;
      int             lat;
      bit             wv;
      int             widx;
      int             wval;
      int             iter;
      bit             to;
      logic [N*W-1:0] aout;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   maxnet_n_if #(.N(N), .W(W), .EPS_W(EPS_W)) bus ();

   maxnet_n #(
      .N(N), .W(W), .EPS_W(EPS_W), .EPS_FRAC(EPS_FRAC), .MAX_ITER(MAX_ITER)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input string nm, input int lat, input bit wv, input int idx,
                               input int val, input int it, input bit to,
                               input logic [N*W-1:0] ao);
      exp_t e;
      e.name = nm; e.st = 0; e.lat = lat; e.wv = wv; e.widx = idx; e.wval = val;
      e.iter = it; e.to = to; e.aout = ao;
      return e;
   endfunction

   // Whole-vector iteration straight from the update rule.
   task automatic model(input logic [N*W-1:0] av, input int eps, output exp_t e, output bit ok);
      longint a[N];
      longint nw[N];
      longint s, p;
      int     it, nz, last;
      bit     running;
      for (int i = 0; i < N; i++) a[i] = longint'(av[i*W +: W]);
      it = 0; nz = 0; last = 0; running = 1'b1; ok = 1'b1;
      e.to = 1'b0;
      while (running) begin
         s = 0;
         for (int i = 0; i < N; i++) s += a[i];
         for (int i = 0; i < N; i++) begin
            p = (longint'(eps) * (s - a[i])) >>> EPS_FRAC;
            nw[i] = (p >= a[i]) ? 0 : a[i] - p;
         end
         nz = 0; last = 0;
         for (int i = 0; i < N; i++) begin
            a[i] = nw[i];
            if (a[i] != 0) begin nz++; last = i; end
         end
         it++;
         if (nz <= 1) running = 1'b0;
`ifdef MAXNET_ITER_LIMIT_EN
         else if (it == MAX_ITER) begin running = 1'b0; e.to = 1'b1; end
`endif
         else if (it >= 100) begin running = 1'b0; ok = 1'b0; end
      end
      e.name = "rand"; e.st = 0;
      e.wv   = (nz == 1);
      e.widx = (nz == 1) ? last : 0;
      e.wval = (nz == 1) ? int'(a[last]) : 0;
      e.iter = it;
      e.lat  = 1 + it * (2 * N + 1);
      e.aout = '0;
      for (int i = 0; i < N; i++) e.aout[i*W +: W] = a[i][W-1:0];
   endtask

   task automatic issue(input logic [N*W-1:0] av, input int eps, input exp_t e, input bit push);
      @(negedge clk);
      bus.a_in    = av;
      bus.epsilon = EPS_W'(eps);
      bus.start   = 1'b1;
      e.st = cyc;
      if (push) sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      chk({e.name, ".busy_on"}, 64'(bus.busy), 64'd1);
   endtask

   task automatic wait_drain(input string nm);
      for (int k = 0; k < 3000 && sb.size() != 0; k++) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL %s.no_done: pending=%0d want 0", nm, sb.size());
         sb.delete();
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, ".busy"}, 64'(bus.busy), 64'd0);
      chk({nm, ".done"}, 64'(bus.done), 64'd0);
      chk({nm, ".wv"}, 64'(bus.winner_valid), 64'd0);
      chk({nm, ".widx"}, 64'(bus.winner_idx), 64'd0);
      chk({nm, ".wval"}, 64'(bus.winner_val), 64'd0);
      chk({nm, ".iter"}, 64'(bus.iter_count), 64'd0);
      chk({nm, ".timeout"}, 64'(bus.timeout), 64'd0);
      chk({nm, ".a_out"}, 64'(bus.a_out), 64'd0);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && bus.done) begin
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done: got done=1 want none at cyc %0d", cyc);
         end else begin
            e = sb.pop_front();
            chk({e.name, ".latency"}, 64'(cyc - e.st - 1), 64'(e.lat));
            chk({e.name, ".busy_off"}, 64'(bus.busy), 64'd0);
            chk({e.name, ".wv"}, 64'(bus.winner_valid), 64'(e.wv));
            chk({e.name, ".widx"}, 64'(bus.winner_idx), 64'(e.widx));
            chk({e.name, ".wval"}, 64'(bus.winner_val), 64'(e.wval));
            chk({e.name, ".iter"}, 64'(bus.iter_count), 64'(e.iter));
            chk({e.name, ".timeout"}, 64'(bus.timeout), 64'(e.to));
            chk({e.name, ".a_out"}, 64'(bus.a_out), 64'(e.aout));
         end
      end
   end

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   localparam logic [N*W-1:0] A_CASE1 = {16'd40, 16'd30, 16'd20, 16'd10};
   localparam logic [N*W-1:0] A_OTHER = {16'd9, 16'd900, 16'd3, 16'd500};

   initial begin : driver
      exp_t          e1, e;
      logic [N*W-1:0] av;
      int            eps;
      bit            ok;

      bus.start = 1'b0; bus.epsilon = '0; bus.a_in = '0;
      e1 = mk("case1", 73, 1'b1, 3, 25, 8, 1'b0, {16'd25, 16'd0, 16'd0, 16'd0});

      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;

      issue(A_CASE1, 32'h020, e1, 1'b1);
      wait_drain("case1");
      repeat (3) @(negedge clk);
      chk("case1.hold_wval", 64'(bus.winner_val), 64'd25);

      issue('0, 32'h020, mk("zeros", 10, 1'b0, 0, 0, 1, 1'b0, '0), 1'b1);
      wait_drain("zeros");

      issue({16'd0, 16'd0, 16'd7, 16'd0}, 32'h020,
            mk("single", 10, 1'b1, 1, 7, 1, 1'b0, {16'd0, 16'd0, 16'd7, 16'd0}), 1'b1);
      wait_drain("single");

`ifdef MAXNET_ITER_LIMIT_EN
      issue({16'd0, 16'd0, 16'd5, 16'd5}, 32'h080,
            mk("cap", 1 + 16 * (2 * N + 1), 1'b0, 0, 0, 16, 1'b1,
               {16'd0, 16'd0, 16'd1, 16'd1}), 1'b1);
      wait_drain("cap");
`endif

      e1.name = "busy_start";
      issue(A_CASE1, 32'h020, e1, 1'b1);
      repeat (20) @(negedge clk);
      bus.a_in = A_OTHER; bus.epsilon = 9'h040; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_drain("busy_start");
      repeat (80) @(negedge clk);

      e1.name = "abort";
      issue(A_CASE1, 32'h020, e1, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_zero("abort");
      repeat (100) @(negedge clk);
      e1.name = "after_abort";
      issue(A_CASE1, 32'h020, e1, 1'b1);
      wait_drain("after_abort");

      for (int r = 0; r < 15; r++) begin
         ok = 1'b0;
         for (int t = 0; t < 50 && !ok; t++) begin
            av = '0;
            for (int i = 0; i < N; i++)
               av[i*W +: W] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 2000));
            eps = int'($urandom_range(16, 511));
            model(av, eps, e, ok);
         end
         if (ok) begin
            e.name = $sformatf("rand%0d", r);
            issue(av, eps, e, 1'b1);
            wait_drain(e.name);
         end
      end

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
